// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared definitions for the instruction-fetch stage.
//               Instruction address/data bus types (InstAddrBus, InstBus),
//               the all-zero word (ZeroWord) and the bubble encoding
//               (32'h0), the hold-buffer record, and the sequential-PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  // InstAddrBus / InstBus widths
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;

  // ZeroWord and the encoding placed on inst_o for a bubble
  localparam inst_bus_t ZERO_WORD   = 32'h0;
  localparam inst_bus_t BUBBLE_INST = 32'h0;

  // One fetched word together with the PC and prediction it was fetched with
  typedef struct packed {
    inst_addr_bus_t pc;
    inst_bus_t      inst;
    logic           taken;
  } fetch_word_t;

  // Fall-through PC; wraps modulo 2^32
  function automatic inst_addr_bus_t seq_pc(input inst_addr_bus_t cur);
    return cur + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_btb.sv
// ============================================================================
// Module      : if_stage_btb
// Description : Direct-mapped branch target buffer. One combinational lookup
//               port and one synchronous write port. A lookup in the same
//               cycle as a write to the same index returns the old contents.
// Ports       : clk, rst_n      - clock, async active-low reset (valid bits)
//               en              - global enable; 0 blocks writes
//               we, waddr,
//               wtarget         - write branch PC / target, sets valid bit
//               raddr           - lookup PC
//               hit, target     - lookup result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_btb
  import if_stage_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           we,
  input  inst_addr_bus_t waddr,
  input  inst_addr_bus_t wtarget,
  input  inst_addr_bus_t raddr,
  output logic           hit,
  output inst_addr_bus_t target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = INST_ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  inst_addr_bus_t     targets [ENTRIES];

  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] rtag;
  logic [TAG_W-1:0] wtag;

  assign ridx = raddr[IDX_W+1:2];
  assign widx = waddr[IDX_W+1:2];
  assign rtag = raddr[INST_ADDR_W-1:IDX_W+2];
  assign wtag = waddr[INST_ADDR_W-1:IDX_W+2];

  // Instructions are word aligned, so the byte offset takes no part.
  logic unused_offset;
  assign unused_offset = ^{raddr[1:0], waddr[1:0]};

  // Only the valid bits need reset; tag/target are qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (en && we) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      tags[widx]    <= wtag;
      targets[widx] <= wtarget;
    end
  end

  assign hit    = valid[ridx] && (tags[ridx] == rtag);
  assign target = targets[ridx];

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Holds the PC, fetches words over a
//               req/ack handshake, predicts the next PC with a BTB, redirects
//               on execute mispredictions and absorbs decode stalls with a
//               one-entry hold buffer. IF/ID outputs are registered.
// Config      : IF_BTB_EN - when defined the BTB is built and predicts; when
//               undefined the next PC is always pc+4 and taken_o stays 0.
// Ports       : clk, rst_n, rdy           - clock, async reset, global enable
//               stall_i                   - decode stall
//               redirect_i, redirect_pc_i - execute redirect and target
//               if_req_o, if_addr_o,
//               if_ack_i, if_inst_i       - memory fetch handshake
//               b_we_i, b_waddr_i,
//               b_wtarget_i               - BTB write from decode
//               pc_o, inst_o, taken_o,
//               valid_o                   - IF/ID outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BTB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_inst_i,
  input  logic        b_we_i,
  input  logic [31:0] b_waddr_i,
  input  logic [31:0] b_wtarget_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        taken_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  inst_addr_bus_t pc;
  inst_addr_bus_t drain_pc;
  fetch_word_t    hold_buf;

  inst_addr_bus_t npc;
  logic           pred_taken;

`ifdef IF_BTB_EN
  logic           btb_hit;
  inst_addr_bus_t btb_target;

  if_stage_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rdy),
    .we      (b_we_i),
    .waddr   (b_waddr_i),
    .wtarget (b_wtarget_i),
    .raddr   (pc),
    .hit     (btb_hit),
    .target  (btb_target)
  );

  assign pred_taken = btb_hit;
  assign npc        = btb_hit ? btb_target : seq_pc(pc);
`else
  // Without a BTB the write port and the depth have no effect.
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_btb_write;
  assign unused_btb_write = ^{b_we_i, b_waddr_i, b_wtarget_i};

  assign pred_taken = 1'b0;
  assign npc        = seq_pc(pc);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drain_pc  <= RESET_PC;
      hold_buf  <= '0;
      if_req_o  <= 1'b0;
      if_addr_o <= RESET_PC;
      pc_o      <= ZERO_WORD;
      inst_o    <= BUBBLE_INST;
      taken_o   <= 1'b0;
      valid_o   <= 1'b0;
    end else if (rdy) begin
      // A redirect always kills whatever decode would see next; the
      // hold buffer is dropped implicitly by leaving HOLD below.
      if (redirect_i) begin
        valid_o <= 1'b0;
        inst_o  <= BUBBLE_INST;
      end

      unique case (state)
        IDLE: begin
          state    <= FETCH;
          if_req_o <= 1'b1;
          if (redirect_i) begin
            pc        <= redirect_pc_i;
            if_addr_o <= redirect_pc_i;
          end else begin
            if_addr_o <= pc;
          end
        end

        FETCH: begin
          if (redirect_i) begin
            if (if_ack_i) begin
              // Word arriving now is from the wrong path; restart at once.
              pc        <= redirect_pc_i;
              if_addr_o <= redirect_pc_i;
            end else begin
              // Request must stay stable until its ack, so park the target.
              drain_pc <= redirect_pc_i;
              state    <= DRAIN;
            end
          end else if (if_ack_i) begin
            pc        <= npc;
            if_addr_o <= npc;
            if (stall_i) begin
              hold_buf <= '{pc: pc, inst: if_inst_i, taken: pred_taken};
              if_req_o <= 1'b0;
              state    <= HOLD;
            end else begin
              pc_o    <= pc;
              inst_o  <= if_inst_i;
              taken_o <= pred_taken;
              valid_o <= 1'b1;
            end
          end else if (!stall_i) begin
            valid_o <= 1'b0;
            inst_o  <= BUBBLE_INST;
          end
        end

        HOLD: begin
          if (redirect_i) begin
            pc        <= redirect_pc_i;
            if_addr_o <= redirect_pc_i;
            if_req_o  <= 1'b1;
            state     <= FETCH;
          end else if (!stall_i) begin
            // if_addr_o already holds the predicted PC set at the ack.
            pc_o     <= hold_buf.pc;
            inst_o   <= hold_buf.inst;
            taken_o  <= hold_buf.taken;
            valid_o  <= 1'b1;
            if_req_o <= 1'b1;
            state    <= FETCH;
          end
        end

        DRAIN: begin
          if (if_ack_i) begin
            // Discard the stale word; a same-cycle redirect is the newest.
            if (redirect_i) begin
              pc        <= redirect_pc_i;
              if_addr_o <= redirect_pc_i;
            end else begin
              pc        <= drain_pc;
              if_addr_o <= drain_pc;
            end
            state <= FETCH;
          end else if (redirect_i) begin
            drain_pc <= redirect_pc_i;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. Memory words are
//               address + 0x13, so the word at address 0 is 32'h00000013.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_ack_i = 1'b0;
  logic [31:0] if_inst_i = 32'h0;
  logic        b_we_i = 1'b0;
  logic [31:0] b_waddr_i = 32'h0;
  logic [31:0] b_wtarget_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        taken_o;
  logic        valid_o;

  int tests = 0;
  int fails = 0;

`ifdef IF_BTB_EN
  localparam logic [31:0] EXP_AFTER_10 = 32'h40;
  localparam logic [31:0] EXP_TAKEN_10 = 32'h1;
`else
  localparam logic [31:0] EXP_AFTER_10 = 32'h14;
  localparam logic [31:0] EXP_TAKEN_10 = 32'h0;
`endif

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC    (32'h0),
    .BTB_ENTRIES (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_req_o      (if_req_o),
    .if_addr_o     (if_addr_o),
    .if_ack_i      (if_ack_i),
    .if_inst_i     (if_inst_i),
    .b_we_i        (b_we_i),
    .b_waddr_i     (b_waddr_i),
    .b_wtarget_i   (b_wtarget_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .taken_o       (taken_o),
    .valid_o       (valid_o)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h13;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [31:0] a);
    if_ack_i  = 1'b1;
    if_inst_i = word_at(a);
    step();
    if_ack_i  = 1'b0;
    if_inst_i = 32'h0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_req",   {31'b0, if_req_o}, 32'h0);
    chk("rst_addr",  if_addr_o,         32'h0);
    chk("rst_pc_o",  pc_o,              32'h0);
    chk("rst_inst",  inst_o,            32'h0);
    chk("rst_taken", {31'b0, taken_o},  32'h0);
    chk("rst_valid", {31'b0, valid_o},  32'h0);

    // Release reset; IDLE -> FETCH on the first enabled edge
    rst_n = 1'b1;
    step();
    chk("first_req",  {31'b0, if_req_o}, 32'h1);
    chk("first_addr", if_addr_o,         32'h0);
    step();
    step();
    chk("req_stable_req",  {31'b0, if_req_o}, 32'h1);
    chk("req_stable_addr", if_addr_o,         32'h0);
    ack(32'h0);
    chk("w0_pc_o",  pc_o,              32'h0);
    chk("w0_inst",  inst_o,            32'h00000013);
    chk("w0_valid", {31'b0, valid_o},  32'h1);
    chk("w0_next",  if_addr_o,         32'h4);
    chk("w0_req",   {31'b0, if_req_o}, 32'h1);
    step();
    chk("bubble_valid", {31'b0, valid_o}, 32'h0);
    chk("bubble_inst",  inst_o,           32'h0);

    // BTB entry 0x10 -> 0x40
    b_we_i      = 1'b1;
    b_waddr_i   = 32'h10;
    b_wtarget_i = 32'h40;
    step();
    b_we_i = 1'b0;
    ack(32'h4);
    chk("w4_pc_o",  pc_o,             32'h4);
    chk("w4_valid", {31'b0, valid_o}, 32'h1);
    chk("w4_next",  if_addr_o,        32'h8);

    // Stall on the ack for 0x8
    stall_i = 1'b1;
    ack(32'h8);
    chk("hold_req",   {31'b0, if_req_o}, 32'h0);
    chk("hold_pc_o",  pc_o,              32'h4);
    chk("hold_valid", {31'b0, valid_o},  32'h1);
    step();
    chk("hold2_req",  {31'b0, if_req_o}, 32'h0);
    chk("hold2_pc_o", pc_o,              32'h4);
    stall_i = 1'b0;
    step();
    chk("unhold_pc_o",  pc_o,              32'h8);
    chk("unhold_inst",  inst_o,            32'h0000001B);
    chk("unhold_valid", {31'b0, valid_o},  32'h1);
    chk("unhold_req",   {31'b0, if_req_o}, 32'h1);
    chk("unhold_addr",  if_addr_o,         32'hC);

    ack(32'hC);
    chk("wC_pc_o", pc_o,      32'hC);
    chk("wC_next", if_addr_o, 32'h10);
    ack(32'h10);
    chk("w10_pc_o",  pc_o,             32'h10);
    chk("w10_taken", {31'b0, taken_o}, EXP_TAKEN_10);
    chk("w10_next",  if_addr_o,        EXP_AFTER_10);

    // Redirect and ack in the same cycle
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h20;
    ack(EXP_AFTER_10);
    redirect_i = 1'b0;
    chk("rdack_addr",  if_addr_o,         32'h20);
    chk("rdack_req",   {31'b0, if_req_o}, 32'h1);
    chk("rdack_valid", {31'b0, valid_o},  32'h0);
    chk("rdack_inst",  inst_o,            32'h0);

    // Redirect two cycles before the ack for 0x20
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    chk("drain_addr",  if_addr_o,         32'h20);
    chk("drain_req",   {31'b0, if_req_o}, 32'h1);
    chk("drain_valid", {31'b0, valid_o},  32'h0);
    step();
    chk("drain2_addr", if_addr_o,         32'h20);
    chk("drain2_req",  {31'b0, if_req_o}, 32'h1);
    ack(32'h20);
    chk("drained_addr",  if_addr_o,         32'h100);
    chk("drained_req",   {31'b0, if_req_o}, 32'h1);
    chk("drained_valid", {31'b0, valid_o},  32'h0);
    chk("drained_inst",  inst_o,            32'h0);
    step();
    chk("drained2_valid", {31'b0, valid_o}, 32'h0);

    ack(32'h100);
    chk("w100_pc_o",  pc_o,             32'h100);
    chk("w100_valid", {31'b0, valid_o}, 32'h1);
    chk("w100_next",  if_addr_o,        32'h104);

    // rdy low for 5 cycles; stall/redirect must be ignored meanwhile
    rdy           = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_addr",  if_addr_o,         32'h104);
      chk("frz_req",   {31'b0, if_req_o}, 32'h1);
      chk("frz_valid", {31'b0, valid_o},  32'h1);
      chk("frz_pc_o",  pc_o,              32'h100);
      chk("frz_inst",  inst_o,            32'h00000113);
    end
    rdy        = 1'b1;
    redirect_i = 1'b0;
    ack(32'h104);
    chk("resume_pc_o",  pc_o,             32'h104);
    chk("resume_inst",  inst_o,           32'h00000117);
    chk("resume_valid", {31'b0, valid_o}, 32'h1);
    chk("resume_next",  if_addr_o,        32'h108);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage feeding the decode stage through its own registered IF/ID outputs. It holds the PC and issues word-fetch requests to the memory controller over a req/ack handshake. It predicts the next PC with a direct-mapped branch target buffer that the decode stage writes, and it redirects on mispredictions reported by execute. It absorbs decode-stage stalls with a one-entry hold buffer.

## Interface
- `RESET_PC`, 32'h0, PC fetched first after reset.
- `BTB_ENTRIES`, 64, BTB depth; power of two, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; 0 freezes all state, and outputs hold their values.
- `stall_i`  in  1  decode stalled; IF/ID outputs must hold.
- `redirect_i`  in  1  mispredict or jump-resolve from execute.
- `redirect_pc_i`  in  32  correct next PC.
- `if_req_o`  out  1  fetch request to the memory controller.
- `if_addr_o`  out  32  fetch address.
- `if_ack_i`  in  1  single-cycle pulse; the word is valid on `if_inst_i`.
- `if_inst_i`  in  32  fetched instruction.
- `b_we_i`  in  1  BTB write from decode.
- `b_waddr_i`  in  32  branch PC to write.
- `b_wtarget_i`  in  32  branch target to write.
- `pc_o`  out  32  PC of the instruction on `inst_o`.
- `inst_o`  out  32  instruction to decode; 32'h0 when a bubble.
- `taken_o`  out  1  prediction used for `pc_o`.
- `valid_o`  out  1  `inst_o` is a real instruction.

## Operation
- **Reset values:**
  - `pc`=RESET_PC; state IDLE.
  - `if_req_o`=0, `if_addr_o`=RESET_PC.
  - `pc_o`=0, `inst_o`=0, `taken_o`=0, `valid_o`=0.
  - Hold buffer empty; all BTB valid bits cleared.
- **States:**
  - IDLE: moves to FETCH on the next enabled cycle.
  - FETCH: `if_req_o`=1, `if_addr_o`=`pc`.
  - HOLD: a word has been fetched and is buffered; `if_req_o`=0.
  - DRAIN: a redirect arrived while a request was outstanding; `if_req_o`=1 with the old address.
- **Handshake:** `if_req_o` and `if_addr_o` stay stable from assertion until the cycle `if_ack_i`=1. A new address may be presented the cycle after the ack (back-to-back requests allowed).
- **Prediction:** `npc` = BTB target if there is a BTB hit on `pc`, else `pc`+4 (32-bit, wraps mod 2^32). `taken` = hit.
- **FETCH + ack, no redirect:**
  - If `stall_i`=0: outputs ← {`pc`, `if_inst_i`, `taken`, 1}; `pc` ← `npc`; stay in FETCH.
  - If `stall_i`=1: buffer ← {`pc`, `if_inst_i`, `taken`}; `pc` ← `npc`; go to HOLD.
- **FETCH without ack:** if `stall_i`=0, outputs become a bubble (`valid_o`=0, `inst_o`=0). If `stall_i`=1, outputs hold.
- **HOLD:** when `stall_i`=0, outputs ← buffer with `valid_o`=1, and go to FETCH.
- **Redirect (priority over everything):**
  - `valid_o` ← 0, `inst_o` ← 0; the buffer is dropped.
  - In FETCH without ack: latch `redirect_pc_i` and go to DRAIN.
  - In FETCH with ack in the same cycle, or in IDLE or HOLD: `pc` ← `redirect_pc_i` and go to FETCH.
  - In DRAIN: the newer `redirect_pc_i` overwrites the latched target.
- **DRAIN + ack:** discard the word; `pc` ← latched target; go to FETCH.
- **BTB:**
  - Index = `pc[log2(BTB_ENTRIES)+1:2]`; tag = the remaining upper bits; one valid bit per entry.
  - Hit = valid and tag match.
  - A write replaces the entry and sets its valid bit.
  - A lookup in the same cycle as a write to the same index sees the old contents.

## Timing
- Fetch-to-decode latency is the memory latency plus 1. The word appears on the outputs the cycle after its ack.
- Redirect penalty: the first request to `redirect_pc_i` is issued the cycle after the redirect, or after the outstanding ack when draining.
- A redirect is always acted on at the edge where it is sampled; no flag or output carries it to a later cycle.
- `rdy`=0 overrides `stall_i` and `redirect_i`; those inputs are ignored while `rdy`=0.
- Asserting `rst_n` low mid-request abandons the request. The memory controller is reset by the same signal.

## Configuration
- `IF_BTB_EN` defined: BTB instantiated, and prediction operates as described above.
- `IF_BTB_EN` undefined:
  - No BTB storage; `b_*` inputs are ignored.
  - `npc` = `pc`+4 and `taken_o`=0 always.

## Structure
- The shared defines header holds `InstAddrBus`, `InstBus`, `ZeroWord` and the bubble encoding 32'h0.
- FSM state encodings stay local to the block.
- One sub-module, `btb`: a direct-mapped table with one combinational lookup port and one synchronous write port.

## Test plan
- Reset release, ack after 3 cycles with 32'h00000013 → `if_addr_o`=0, then `pc_o`=0, `inst_o`=32'h13, `valid_o`=1; next request to address 4.
- BTB write {0x10, 0x40}, then fetch at 0x10 → next `if_addr_o`=0x40 and `taken_o`=1. With `IF_BTB_EN` undefined: next address 0x14, `taken_o`=0.
- `stall_i`=1 on the ack for 0x8 → HOLD with `if_req_o`=0. When the stall drops: `pc_o`=0x8, `valid_o`=1, then a request to 0xC.
- Redirect to 0x100 two cycles before the ack for 0x20 → request stays on 0x20 until the ack, the word is discarded, the next request is 0x100, and no valid output is produced for 0x20.
- Redirect and ack in the same cycle → word discarded, next `if_addr_o`=0x100, `valid_o`=0.
- `rdy`=0 for 5 cycles mid-request → request and outputs frozen; operation resumes unchanged when `rdy` returns to 1.
